uart_tx_serializer: RTL and testbench

Transmit stage of the APB serial block; sits directly downstream of the TX FIFO and consumes its output. Pops one word when the FIFO is non-empty and transmission is enabled, then serializes it on tx as an 8N1/8N2 UART frame at a programmable bit period. Back-to-back frames with no idle gap while the FIFO holds data.

---
 rtl/uart_tx_serializer.sv | 129 ++++++++++++
 tb/tb_uart_tx_serializer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: pops TX FIFO words and sends them as 8N1/8N2 UART frames at a programmable bit period.
// Optional parity bit (and parity_odd port) when UART_TX_PARITY_EN is defined.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_enable,
    input  logic [DIV_WIDTH-1:0]  baud_div,
    input  logic                  stop2,
    input  logic                  fifoEmpty,
    input  logic [DATA_WIDTH-1:0] rData,
`ifdef UART_TX_PARITY_EN
    input  logic                  parity_odd,
`endif
    output logic                  rEnable,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done
);
    localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST = BW'(DATA_WIDTH - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                state, state_n;
    logic [DIV_WIDTH-1:0]  cnt, cnt_n, div_l;
    logic [BW-1:0]         bit_idx, bit_n;
    logic                  stop_idx, stop_n, stop2_l;
    logic [DATA_WIDTH-1:0] shreg, shreg_n;
    logic                  tx_n, bit_end, last_stop, pop;
`ifdef UART_TX_PARITY_EN
    logic                  par_l;
`endif

    assign bit_end   = cnt == '0;
    assign last_stop = state == STOP && bit_end && stop_idx == stop2_l;
    assign pop       = tx_enable && !fifoEmpty && (state == IDLE || last_stop);
    assign rEnable   = pop;
    assign tx_busy   = state != IDLE;
    assign tx_done   = last_stop;

    always_comb begin
        state_n = state;
        cnt_n   = state == IDLE ? cnt : cnt - DIV_WIDTH'(1);
        bit_n   = bit_idx;
        stop_n  = stop_idx;
        shreg_n = shreg;
        tx_n    = tx;
        if (pop) begin
            state_n = START;
            cnt_n   = baud_div;
            bit_n   = '0;
            stop_n  = 1'b0;
            shreg_n = rData;
            tx_n    = 1'b0;
        end else if (state != IDLE && bit_end) begin
            cnt_n = div_l;
            case (state)
                START: begin
                    state_n = DATA;
                    tx_n    = shreg[0];
                end
                DATA: begin
                    bit_n   = bit_idx + BW'(1);
                    shreg_n = shreg >> 1;
                    tx_n    = shreg_n[0];
                    if (bit_idx == LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
                        tx_n    = par_l;
`else
                        state_n = STOP;
                        tx_n    = 1'b1;
`endif
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    state_n = STOP;
                    tx_n    = 1'b1;
                end
`endif
                STOP: begin
                    tx_n = 1'b1;
                    if (last_stop) state_n = IDLE;
                    else stop_n = 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Frame settings are captured only at the pop so mid-frame changes cannot disturb timing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            div_l    <= '0;
            stop2_l  <= 1'b0;
            tx       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_l    <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_idx  <= bit_n;
            stop_idx <= stop_n;
            shreg    <= shreg_n;
            tx       <= tx_n;
            if (pop) begin
                div_l   <= baud_div;
                stop2_l <= stop2;
`ifdef UART_TX_PARITY_EN
                par_l   <= ^rData ^ parity_odd;
`endif
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: bench for uart_tx_serializer; a FIFO queue and a per-cycle expected tx waveform queue form the model.
module tb_uart_tx_serializer;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    logic        clk = 0, rst = 0, tx_enable = 0, stop2 = 0, fifoEmpty = 1, parity_odd = 0;
    logic [15:0] baud_div = 0;
    logic [7:0]  rData = 0;
    logic        rEnable, tx, tx_busy, tx_done;
    int          total = 0, bad = 0, cyc = 0, pops = 0, dones = 0, busy_cyc = 0;
    int          pop_at[$], done_at[$];
    logic [7:0]  fq[$];
    bit          eq[$];

    uart_tx_serializer dut (
        .clk(clk), .rst(rst), .tx_enable(tx_enable), .baud_div(baud_div), .stop2(stop2),
        .fifoEmpty(fifoEmpty), .rData(rData),
`ifdef UART_TX_PARITY_EN
        .parity_odd(parity_odd),
`endif
        .rEnable(rEnable), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Appends the whole frame, one entry per clock cycle, to the expected waveform.
    function automatic void build(input logic [7:0] d, input int div, input bit s2, input bit po);
        bit b[$];
        b.push_back(1'b0);
        for (int i = 0; i < 8; i++) b.push_back(d[i]);
        if (PB == 1) b.push_back(^d ^ po);
        b.push_back(1'b1);
        if (s2) b.push_back(1'b1);
        foreach (b[i]) for (int k = 0; k <= div; k++) eq.push_back(b[i]);
    endfunction

    task automatic clr();
        pops = 0; dones = 0; busy_cyc = 0;
        pop_at.delete(); done_at.delete();
    endtask

    task automatic step(input bit en, input int div, input bit s2, input bit fe, input bit po);
        bit ep;
        @(negedge clk);
        tx_enable = en; baud_div = 16'(div); stop2 = s2; parity_odd = po;
        fifoEmpty = fe || fq.size() == 0;
        rData = fq.size() != 0 ? fq[0] : 8'($urandom);
        #1;
        ep = en && !fifoEmpty && eq.size() <= 1;
        chk("rEnable", rEnable, ep);
        chk("tx", tx, eq.size() != 0 ? eq[0] : 1'b1);
        chk("tx_busy", tx_busy, eq.size() != 0);
        chk("tx_done", tx_done, eq.size() == 1);
        if (rEnable) begin pops++; pop_at.push_back(cyc); end
        if (tx_done) begin dones++; done_at.push_back(cyc); end
        if (tx_busy) busy_cyc++;
        @(posedge clk);
        cyc++;
        if (eq.size() != 0) void'(eq.pop_front());
        if (ep) build(fq.pop_front(), div, s2, po);
    endtask

    initial begin
        build(8'hA5, 3, 0, 0);
        chk("model_a5_len", eq.size(), (10 + PB) * 4);
        chk("model_a5_start", eq[0], 0);
        chk("model_a5_b0", eq[4], 1);
        chk("model_a5_b1", eq[8], 0);
        chk("model_a5_stop", eq[eq.size() - 1], 1);
        eq.delete();
        build(8'h3C, 1, 1, 0);
        chk("model_3c_len", eq.size(), (11 + PB) * 2);
        chk("model_3c_b7", eq[17], 0);
        chk("model_3c_tail", eq[eq.size() - 4] & eq[eq.size() - 3] & eq[eq.size() - 2] & eq[eq.size() - 1], 1);
        eq.delete();
`ifdef UART_TX_PARITY_EN
        build(8'hA5, 0, 0, 0); chk("model_par_a5_even", eq[9], 0); eq.delete();
        build(8'h07, 0, 0, 0); chk("model_par_07_even", eq[9], 1); eq.delete();
        build(8'hA5, 0, 0, 1); chk("model_par_a5_odd", eq[9], 1); eq.delete();
`endif

        #1 rst = 1;
        #1;
        chk("rst_tx", tx, 1); chk("rst_rEnable", rEnable, 0);
        chk("rst_busy", tx_busy, 0); chk("rst_done", tx_done, 0);
        @(negedge clk); rst = 0;

        clr(); fq.push_back(8'hA5);
        repeat (50) step(1, 3, 0, 0, 0);
        chk("a5_pops", pops, 1);
        chk("a5_latency", done_at.size() == 1 && pop_at.size() == 1 ? done_at[0] - pop_at[0] : -1, (10 + PB) * 4);
        chk("a5_busy", busy_cyc, (10 + PB) * 4);

        clr(); fq.push_back(8'h01); fq.push_back(8'hFF);
        repeat (30) step(1, 0, 0, 0, 0);
        chk("b2b_pops", pops, 2);
        chk("b2b_gap", pop_at.size() == 2 ? pop_at[1] - pop_at[0] : -1, 10 + PB);
        chk("b2b_dones", dones, 2);
        chk("b2b_idle", tx_busy, 0);

        clr(); fq.push_back(8'h99);
        repeat (100) step(0, 2, 0, 0, 0);
        repeat (100) step(1, 2, 0, 1, 0);
        chk("hold_pops", pops, 0); chk("hold_busy", busy_cyc, 0);
        fq.delete();

        clr(); fq.push_back(8'h3C); fq.push_back(8'h55);
        repeat (5) step(1, 1, 1, 0, 0);
        repeat (115) step(1, 7, 1, 0, 0);
        chk("div_pops", pops, 2);
        chk("div_f1", done_at.size() == 2 && pop_at.size() == 2 ? done_at[0] - pop_at[0] : -1, (11 + PB) * 2);
        chk("div_f2", done_at.size() == 2 && pop_at.size() == 2 ? done_at[1] - pop_at[1] : -1, (11 + PB) * 8);

        clr(); fq.push_back(8'hA5);
        repeat (18) step(1, 3, 0, 0, 0);
        #1;
        chk("pre_rst_tx_bit3", tx, 0);
        @(negedge clk); rst = 1;
        #1;
        chk("mid_rst_tx", tx, 1); chk("mid_rst_busy", tx_busy, 0);
        eq.delete();
        @(negedge clk); rst = 0;
        clr();
        repeat (20) step(1, 3, 0, 0, 0);
        chk("post_rst_pops", pops, 0);

        clr();
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 3) == 0 && fq.size() < 4) fq.push_back(8'($urandom));
            step($urandom_range(0, 9) != 0, $urandom_range(0, 2), 1'($urandom), $urandom_range(0, 19) == 0, 1'($urandom));
        end
        chk("rand_activity", pops > 20, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
